// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency video-memory read port between
// several render-engine read channels, one outstanding access at a time.
module mem_read_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          CLK,
    input  logic                          RSTb,
    input  logic [NUM_CH*ADDR_BITS-1:0]   ch_address,
    input  logic [NUM_CH-1:0]             ch_rvalid,
    output logic [NUM_CH-1:0]             ch_rready,
    output logic [DATA_BITS-1:0]          ch_data,
    output logic [ADDR_BITS-1:0]          mem_address,
    output logic                          mem_rd,
    input  logic [DATA_BITS-1:0]          mem_data,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_CH);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [ADDR_BITS-1:0] addr_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
        assign addr_arr[i] = ch_address[i*ADDR_BITS +: ADDR_BITS];
    end

    // Search starts one past the last winner and wraps, so the last winner
    // is considered only when nobody else is requesting.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_CH);
            if (!found && ch_rvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign busy = (state != ARB);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= ARB;
            grant       <= '0;
            last_grant  <= GW'(NUM_CH - 1);
            cnt         <= '0;
            mem_rd      <= 1'b0;
            mem_address <= '0;
            ch_rready   <= '0;
            ch_data     <= '0;
        end else begin
            case (state)
                ARB: begin
                    ch_rready <= '0;
                    if (found) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        mem_address <= addr_arr[pick];
                        mem_rd      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rd <= 1'b0;
                    cnt    <= CW'(MEM_LATENCY - 1);
                    state  <= WAIT;
                end
                WAIT: begin
                    // mem_data is only meaningful in the cycle the count reaches zero.
                    if (cnt == '0) begin
                        ch_data   <= mem_data;
                        ch_rready <= ONE << grant;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    ch_rready <= '0;
                    state     <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    a_rready_onehot: assert property (@(posedge CLK) disable iff (!RSTb) $onehot0(ch_rready));
    a_rready_resp:   assert property (@(posedge CLK) disable iff (!RSTb) (|ch_rready) |-> (state == RESP));
    a_rd_issue:      assert property (@(posedge CLK) disable iff (!RSTb) mem_rd |-> (state == ISSUE));

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model. Two instances (latency 1 and 3).
module tb_mem_read_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic CLK = 1'b0;
    logic RSTb = 1'b0;
    logic [NCH*AW-1:0] ch_address = '0;
    logic [NCH-1:0]    ch_rvalid = '0;
    logic [NCH-1:0]    ch_rvalid3 = '0;

    logic [NCH-1:0] rready1, rready3;
    logic [DW-1:0]  data1, data3, mdata1, mdata3;
    logic [AW-1:0]  maddr1, maddr3;
    logic           mrd1, mrd3, busy1, busy3;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mem_arr [65536];
    bit            hist_rd1 [5];
    bit            hist_rd3 [5];
    logic [AW-1:0] hist_a1 [5];
    logic [AW-1:0] hist_a3 [5];

    always #5 CLK = ~CLK;

    mem_read_arbiter #(.NUM_CH(NCH), .ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(1)) u_dut1 (
        .CLK(CLK), .RSTb(RSTb), .ch_address(ch_address), .ch_rvalid(ch_rvalid),
        .ch_rready(rready1), .ch_data(data1), .mem_address(maddr1), .mem_rd(mrd1),
        .mem_data(mdata1), .busy(busy1));

    mem_read_arbiter #(.NUM_CH(NCH), .ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(3)) u_dut3 (
        .CLK(CLK), .RSTb(RSTb), .ch_address(ch_address), .ch_rvalid(ch_rvalid3),
        .ch_rready(rready3), .ch_data(data3), .mem_address(maddr3), .mem_rd(mrd3),
        .mem_data(mdata3), .busy(busy3));

    // Memory: word is valid exactly LATENCY cycles after the mem_rd cycle, random otherwise.
    always @(negedge CLK) begin
        for (int i = 4; i > 0; i--) begin
            hist_rd1[i] = hist_rd1[i-1];
            hist_a1[i]  = hist_a1[i-1];
            hist_rd3[i] = hist_rd3[i-1];
            hist_a3[i]  = hist_a3[i-1];
        end
        hist_rd1[0] = mrd1;
        hist_a1[0]  = maddr1;
        hist_rd3[0] = mrd3;
        hist_a3[0]  = maddr3;
        mdata1 = hist_rd1[1] ? mem_arr[hist_a1[1]] : DW'($urandom);
        mdata3 = hist_rd3[3] ? mem_arr[hist_a3[3]] : DW'($urandom);
    end

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        ch_address[ch*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTb = 1'b0;
        ch_rvalid = '0;
        ch_rvalid3 = '0;
        ch_address = '0;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if ({rready1, mrd1, maddr1, data1, busy1} !== '0) begin n_err++;
            $display("FAIL reset_dut1 got %h exp 0", {rready1, mrd1, maddr1, data1, busy1}); end
        n_vec++; if ({rready3, mrd3, maddr3, data3, busy3} !== '0) begin n_err++;
            $display("FAIL reset_dut3 got %h exp 0", {rready3, mrd3, maddr3, data3, busy3}); end
        repeat (3) @(negedge CLK);
        n_vec++; if ({busy1, mrd1, rready1} !== '0) begin n_err++;
            $display("FAIL idle_stays_arb got %h exp 0", {busy1, mrd1, rready1}); end
    endtask

    task automatic test_single();
        logic [NCH-1:0] exp_rr;
        do_reset();
        set_addr(0, 16'h1234);
        ch_rvalid[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            exp_rr = (c == 3) ? 4'b0001 : 4'b0000;
            n_vec++; if (mrd1 !== (c == 1)) begin n_err++; $display("FAIL single_rd c%0d got %b exp %b", c, mrd1, c == 1); end
            n_vec++; if (maddr1 !== 16'h1234) begin n_err++; $display("FAIL single_addr c%0d got %h exp 1234", c, maddr1); end
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL single_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            n_vec++; if (busy1 !== (c <= 3)) begin n_err++; $display("FAIL single_busy c%0d got %b exp %b", c, busy1, c <= 3); end
            if (c == 3) begin
                n_vec++; if (data1 !== 16'hBEEF) begin n_err++; $display("FAIL single_data got %h exp beef", data1); end
                ch_rvalid[0] = 1'b0;
            end
        end
    endtask

    task automatic test_all4();
        logic [AW-1:0]  a [NCH];
        logic [NCH-1:0] exp_rr;
        logic           exp_rd;
        logic [DW-1:0]  exp_d;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            a[i] = AW'($urandom);
            set_addr(i, a[i]);
        end
        ch_rvalid = '1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            exp_rr = '0;
            exp_rd = 1'b0;
            exp_d  = '0;
            for (int i = 0; i < NCH; i++) begin
                if (c == 3 + 4*i) begin exp_rr = 4'b0001 << i; exp_d = mem_arr[a[i]]; end
                if (c == 1 + 4*i) exp_rd = 1'b1;
            end
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL all4_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            n_vec++; if (mrd1 !== exp_rd) begin n_err++; $display("FAIL all4_rd c%0d got %b exp %b", c, mrd1, exp_rd); end
            if (exp_rr != 0) begin
                n_vec++; if (data1 !== exp_d) begin n_err++; $display("FAIL all4_data c%0d got %h exp %h", c, data1, exp_d); end
            end
            ch_rvalid = ch_rvalid & ~rready1;
        end
    endtask

    task automatic test_fairness();
        logic [NCH-1:0] exp_rr;
        int n0;
        n0 = 0;
        do_reset();
        for (int i = 0; i < NCH; i++) set_addr(i, AW'($urandom));
        ch_rvalid[2] = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            @(negedge CLK);
            exp_rr = '0;
            if (c == 3)  exp_rr = 4'b0100;
            if (c == 7)  exp_rr = 4'b1000;
            if (c == 11) exp_rr = 4'b0010;
            if (c >= 15 && (c - 15) % 4 == 0) exp_rr = 4'b0001 << ((2 + (c - 15) / 4) % 4);
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL fair_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            if (c >= 15 && rready1[0]) n0++;
            if (c == 1) ch_rvalid = ch_rvalid | 4'b1010;
            if (c < 11) ch_rvalid = ch_rvalid & ~rready1;
            if (c == 11) ch_rvalid = '1;
            if (c == 43) ch_rvalid = '0;
        end
        n_vec++; if (n0 !== 2) begin n_err++; $display("FAIL fair_ch0_grants got %0d exp 2", n0); end
    endtask

    task automatic test_latency3();
        logic [AW-1:0]  a;
        logic [NCH-1:0] exp_rr;
        logic [DW-1:0]  exp_d;
        do_reset();
        a = AW'($urandom);
        set_addr(1, a);
        ch_rvalid3[1] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            exp_rr = (c == 5) ? 4'b0010 : 4'b0000;
            exp_d  = (c >= 5) ? mem_arr[a] : '0;
            n_vec++; if (mrd3 !== (c == 1)) begin n_err++; $display("FAIL lat3_rd c%0d got %b exp %b", c, mrd3, c == 1); end
            n_vec++; if (rready3 !== exp_rr) begin n_err++; $display("FAIL lat3_rready c%0d got %b exp %b", c, rready3, exp_rr); end
            n_vec++; if (data3 !== exp_d) begin n_err++; $display("FAIL lat3_data c%0d got %h exp %h", c, data3, exp_d); end
            n_vec++; if (busy3 !== (c <= 5)) begin n_err++; $display("FAIL lat3_busy c%0d got %b exp %b", c, busy3, c <= 5); end
            if (c == 5) ch_rvalid3[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0]  a0, a3;
        logic [NCH-1:0] exp_rr;
        do_reset();
        a0 = AW'($urandom);
        a3 = AW'($urandom) | 16'h0001;
        set_addr(1, 16'h1234);
        set_addr(0, a0);
        set_addr(3, a3);
        ch_rvalid[1] = 1'b1;
        repeat (3) @(negedge CLK);
        ch_rvalid[1] = 1'b0;
        ch_rvalid[3] = 1'b1;
        repeat (3) @(negedge CLK);
        n_vec++; if ({busy1, mrd1, rready1} !== 6'b100000) begin n_err++;
            $display("FAIL rstmid_in_wait got %b exp 100000", {busy1, mrd1, rready1}); end
        RSTb = 1'b0;
        ch_rvalid[0] = 1'b1;
        #1;
        n_vec++; if ({rready1, mrd1, maddr1, data1, busy1} !== '0) begin n_err++;
            $display("FAIL rstmid_async_clear got %h exp 0", {rready1, mrd1, maddr1, data1, busy1}); end
        @(negedge CLK);
        n_vec++; if ({rready1, busy1} !== '0) begin n_err++; $display("FAIL rstmid_held got %b exp 0", {rready1, busy1}); end
        @(negedge CLK);
        RSTb = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            exp_rr = (c == 3) ? 4'b0001 : (c == 7) ? 4'b1000 : 4'b0000;
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL rstmid_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            if (c == 3) begin n_vec++; if (data1 !== mem_arr[a0]) begin n_err++; $display("FAIL rstmid_data0 got %h exp %h", data1, mem_arr[a0]); end end
            if (c == 7) begin n_vec++; if (data1 !== mem_arr[a3]) begin n_err++; $display("FAIL rstmid_data3 got %h exp %h", data1, mem_arr[a3]); end end
            ch_rvalid = ch_rvalid & ~rready1;
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        set_addr(0, 16'h0010);
        ch_rvalid[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            n_vec++; if (maddr1 !== 16'h0010) begin n_err++; $display("FAIL addrchg_addr c%0d got %h exp 0010", c, maddr1); end
            if (c == 1) set_addr(0, 16'h0020);
            if (c == 3) begin
                n_vec++; if (rready1 !== 4'b0001) begin n_err++; $display("FAIL addrchg_rready got %b exp 0001", rready1); end
                n_vec++; if (data1 !== 16'hC0DE) begin n_err++; $display("FAIL addrchg_data got %h exp c0de", data1); end
                ch_rvalid[0] = 1'b0;
            end
        end
    endtask

    task automatic test_early_drop();
        logic [NCH-1:0] exp_rr;
        do_reset();
        set_addr(1, AW'($urandom));
        set_addr(2, AW'($urandom));
        ch_rvalid[1] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            exp_rr = (c == 3) ? 4'b0010 : (c == 7) ? 4'b0100 : 4'b0000;
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL drop_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            n_vec++; if (mrd1 !== (c == 1 || c == 5)) begin n_err++; $display("FAIL drop_rd c%0d got %b exp %b", c, mrd1, c == 1 || c == 5); end
            if (c == 1) ch_rvalid[1] = 1'b0;
            if (c == 2) ch_rvalid[2] = 1'b1;
            if (c == 7) ch_rvalid[2] = 1'b0;
        end
    endtask

    // Model: each access occupies the port for 3+LAT cycles starting at its
    // arbitration cycle; the winner is the next requester after the last one.
    task automatic test_random();
        int last, free_at, issue_c, resp_c, cur, win;
        logic [AW-1:0]  cur_addr, exp_maddr;
        logic [DW-1:0]  cur_word, exp_data;
        logic [NCH-1:0] exp_rr;
        last = NCH - 1; free_at = 0; issue_c = -1; resp_c = -1; cur = 0;
        cur_addr = '0; exp_maddr = '0; cur_word = '0; exp_data = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == issue_c) exp_maddr = cur_addr;
            if (c == resp_c) exp_data = cur_word;
            exp_rr = (c == resp_c) ? (4'b0001 << cur) : 4'b0000;
            n_vec++; if (mrd1 !== (c == issue_c)) begin n_err++; $display("FAIL rand_rd c%0d got %b exp %b", c, mrd1, c == issue_c); end
            n_vec++; if (maddr1 !== exp_maddr) begin n_err++; $display("FAIL rand_addr c%0d got %h exp %h", c, maddr1, exp_maddr); end
            n_vec++; if (rready1 !== exp_rr) begin n_err++; $display("FAIL rand_rready c%0d got %b exp %b", c, rready1, exp_rr); end
            n_vec++; if (data1 !== exp_data) begin n_err++; $display("FAIL rand_data c%0d got %h exp %h", c, data1, exp_data); end
            n_vec++; if (busy1 !== (c < free_at)) begin n_err++; $display("FAIL rand_busy c%0d got %b exp %b", c, busy1, c < free_at); end
            for (int i = 0; i < NCH; i++) begin
                if (ch_rvalid[i]) begin
                    if (rready1[i] && $urandom_range(0, 3) != 0) ch_rvalid[i] = 1'b0;
                    else if ($urandom_range(0, 99) == 0) ch_rvalid[i] = 1'b0;
                    else if ($urandom_range(0, 19) == 0) set_addr(i, AW'($urandom));
                end else if ($urandom_range(0, 3) == 0) begin
                    set_addr(i, AW'($urandom));
                    ch_rvalid[i] = 1'b1;
                end
            end
            if (c >= free_at && ch_rvalid != 0) begin
                win = -1;
                for (int k = 1; k <= NCH; k++)
                    if (win < 0 && ch_rvalid[(last + k) % NCH]) win = (last + k) % NCH;
                cur      = win;
                last     = win;
                cur_addr = ch_address[win*AW +: AW];
                cur_word = mem_arr[cur_addr];
                issue_c  = c + 1;
                resp_c   = c + 3;
                free_at  = c + 4;
            end
        end
        ch_rvalid = '0;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = DW'($urandom);
        mem_arr[16'h1234] = 16'hBEEF;
        mem_arr[16'h0010] = 16'hC0DE;
        mem_arr[16'h0020] = 16'h0BAD;
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_latency3();
        test_reset_mid();
        test_addr_change();
        test_early_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
